// File: rtl/adder_16_bit.sv
// Registered two's-complement adder built from carry-lookahead groups.
// One-cycle latency, one operation per cycle, outputs driven only from flops.

// One lookahead group: per-bit generate/propagate, group G/P, and bit sums
// given the carry into the group.
module adder_16_bit_cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_c,
  output logic [GROUP-1:0] o_s,
  output logic             o_g,
  output logic             o_p
);
  logic [GROUP-1:0] w_g, w_p;
  logic [GROUP:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // In-group carries, group generate/propagate
  always_comb begin
    w_c    = '0;
    w_c[0] = i_c;
    o_g    = 1'b0;
    o_p    = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      o_g      = w_g[i] | (w_p[i] & o_g);
      o_p      = o_p & w_p[i];
    end
  end

  assign o_s = w_p ^ w_c[GROUP-1:0];
endmodule

module adder_16_bit #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NGRP = WIDTH / GROUP;

  generate
    if (WIDTH % GROUP != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of GROUP");
    end
  endgenerate

  logic [NGRP-1:0]  w_gg, w_gp;
  logic [NGRP:0]    w_gc;
  logic [WIDTH-1:0] w_sum;
  logic             w_c_msb;
  logic             w_ovf;

  // Group array; each group gets its carry from the second-level lookahead
  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      adder_16_bit_cla_group #(.GROUP(GROUP)) u_grp (
        .i_a (a[gi*GROUP +: GROUP]),
        .i_b (b[gi*GROUP +: GROUP]),
        .i_c (w_gc[gi]),
        .o_s (w_sum[gi*GROUP +: GROUP]),
        .o_g (w_gg[gi]),
        .o_p (w_gp[gi])
      );
    end
  endgenerate

  // Second-level lookahead: group carries c4, c8, c12, c16 from cin
  always_comb begin
    w_gc    = '0;
    w_gc[0] = cin;
    for (int k = 0; k < NGRP; k++)
      w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
  end

  // Sum bit is p ^ carry, so the carry into the MSB falls out of the sum
  assign w_c_msb = w_sum[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
  assign w_ovf   = w_c_msb ^ w_gc[NGRP];

  logic             r_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  // Result register: reset wins, idle cycles hold the result and drop valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_gc[NGRP];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign out_valid = r_vld;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_adder_16_bit.sv
// Directed and random checks of the registered 16-bit adder.
module tb_adder_16_bit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_16_bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  // Apply inputs at negedge, let one rising edge happen, sample 1 time unit later
  task automatic step(input logic r, input logic v, input logic [15:0] ta,
                      input logic [15:0] tb, input logic tc);
    @(negedge clk);
    rst = r; in_valid = v; a = ta; b = tb; cin = tc;
    @(posedge clk);
    #1;
  endtask

  // Compare {out_valid, cout, overflow, sum}
  task automatic chk(input string tag, input logic ev, input logic ec,
                     input logic eo, input logic [15:0] es);
    logic [18:0] obs, exp;
    obs = {out_valid, cout, overflow, sum};
    exp = {ev, ec, eo, es};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got v/c/o/sum=%b/%b/%b/%h exp=%b/%b/%b/%h",
             tag, obs[18], obs[17], obs[16], obs[15:0],
             exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  initial begin
    logic [16:0] ref_full;
    logic        ref_ovf;
    logic [15:0] ra, rb;
    logic        rc;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("reset", 1'b0, 1'b0, 1'b0, 16'h0000);

    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("ffff+ffff+1", 1'b1, 1'b1, 1'b0, 16'hFFFF);
    step(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
    chk("zero", 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    chk("7fff+1", 1'b1, 1'b0, 1'b1, 16'h8000);
    step(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b1);
    chk("7fff+1+1", 1'b1, 1'b0, 1'b1, 16'h8001);
    step(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0);
    chk("8000+8000", 1'b1, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    chk("ripple", 1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0FFF, 16'h0001, 1'b0);
    chk("grp3 carry", 1'b1, 1'b0, 1'b0, 16'h1000);
    step(1'b0, 1'b1, 16'h1234, 16'h1111, 1'b0);
    chk("1234+1111", 1'b1, 1'b0, 1'b0, 16'h2345);

    // Idle cycle: result holds, valid drops
    step(1'b0, 1'b0, 16'hAAAA, 16'h5555, 1'b1);
    chk("hold", 1'b0, 1'b0, 1'b0, 16'h2345);
    step(1'b0, 1'b1, 16'h8000, 16'hFFFF, 1'b0);
    chk("neg ovf", 1'b1, 1'b1, 1'b1, 16'h7FFF);
    step(1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0);
    chk("hold flags", 1'b0, 1'b1, 1'b1, 16'h7FFF);

    // Back-to-back random operations against a 17-bit reference
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      ref_full = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      ref_ovf  = (ra[15] == rb[15]) && (ref_full[15] != ra[15]);
      step(1'b0, 1'b1, ra, rb, rc);
      chk("random", 1'b1, ref_full[16], ref_ovf, ref_full[15:0]);
    end

    // Reset takes priority over a valid operation on the same edge
    step(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b0);
    chk("rst prio", 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h1234, 16'h1111, 1'b0);
    chk("post rst hold", 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'hFFFE, 16'h0001, 1'b0);
    chk("first after rst", 1'b1, 1'b0, 1'b0, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
